kernel_window_sequencer: RTL

Control stage directly upstream of the 8-bit multiply-accumulate kernel accumulator. For one requested centre pixel, it walks the 3x3 window in row-major order and fetches each pixel from the synchronous image buffer. It pairs each pixel with a locally stored Q0.8 kernel coefficient and drives the accumulator's clear/start handshake. When all nine taps are summed, it returns the 8-bit filtered result with a one-cycle done pulse.

---
 rtl/kernel_window_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/kernel_window_sequencer.sv
// Walks the 3x3 window around a requested centre pixel and feeds each
// pixel/coefficient pair to the MAC accumulator through its clear/start handshake.
module kernel_window_sequencer #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          go,
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    input  logic          kw_en,
    input  logic [3:0]    kw_idx,
    input  logic [7:0]    kw_data,
    output logic          pix_re,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    input  logic [7:0]    pix_rdata,
    output logic [7:0]    kernel_v,
    output logic [7:0]    pixel_v,
    output logic          acc_clear,
    output logic          acc_start,
    input  logic          acc_ready,
    input  logic          acc_clear_flag,
    input  logic [7:0]    acc_sum,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, CLR_WAIT, ISSUE, LATCH, FIRE, WAIT_RDY, DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cx_q, cy_q;
    logic [3:0]    k;
    logic [7:0]    coef [9];
    logic [1:0]    kr, kc;
    logic [CW+1:0] tx, ty;
    logic          oob;

    // Tap coordinates carry two extra bits so a wrap below zero lands far above
    // IMG_W/IMG_H, folding the negative check into a single unsigned compare.
    always_comb begin
        kr  = 2'(k / 4'd3);
        kc  = 2'(k % 4'd3);
        tx  = {2'b00, cx_q} + (CW+2)'(kc) - (CW+2)'(1);
        ty  = {2'b00, cy_q} + (CW+2)'(kr) - (CW+2)'(1);
        oob = (tx >= (CW+2)'(IMG_W)) || (ty >= (CW+2)'(IMG_H));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (go) state_nx = CLEAR;
            CLEAR:    state_nx = CLR_WAIT;
            CLR_WAIT: if (acc_clear_flag) state_nx = ISSUE;
            ISSUE:    state_nx = LATCH;
            LATCH:    state_nx = FIRE;
            FIRE:     if (!acc_ready) state_nx = WAIT_RDY;
            WAIT_RDY: if (acc_ready) state_nx = (k == 4'd8) ? DONE : ISSUE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        acc_clear = (state == CLEAR);
        acc_start = (state == FIRE) && !acc_ready;
        pix_re    = (state == ISSUE) && !oob;
        pix_x     = (state == ISSUE) ? tx[CW-1:0] : '0;
        pix_y     = (state == ISSUE) ? ty[CW-1:0] : '0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cx_q     <= '0;
            cy_q     <= '0;
            k        <= '0;
            kernel_v <= '0;
            pixel_v  <= '0;
            result   <= '0;
            for (int unsigned i = 0; i < 9; i++) coef[i] <= '0;
        end else begin
            if (state == IDLE) begin
                if (go) begin
                    cx_q <= cx;
                    cy_q <= cy;
                    k    <= '0;
                end
                if (kw_en && kw_idx <= 4'd8) coef[kw_idx] <= kw_data;
            end
            if (state == LATCH) begin
                kernel_v <= coef[k];
                pixel_v  <= oob ? 8'd0 : pix_rdata;
            end
            if (state == WAIT_RDY && acc_ready) begin
                if (k == 4'd8) result <= acc_sum;
                else           k      <= k + 4'd1;
            end
        end
    end

endmodule
